// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    // Width of the optional statistics counters.
    localparam int STAT_WIDTH = 16;

    // Arbiter FSM: idle/issue, or waiting one cycle for read data.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CORE = 2'd1,
        RD_HOST = 2'd2
    } arb_state_t;

    // Which requester drives the memory port this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } arb_owner_t;

    // Saturating increment for statistics counters.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive denied host cycles; at_limit forces a host grant.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int              CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data memory between the core (fixed priority)
// and a host loader/debug port, with a starvation override for the host.
// Define DMEM_ARB_STATS_EN to add the stall/grant statistics outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_req,
    input  logic                     core_we,
    input  logic [ADDRESS_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]    core_wdata,
    input  logic                     core_byte_en,
    output logic [DATA_WIDTH-1:0]    core_rdata,
    output logic                     core_rvalid,
    output logic                     core_stall,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDRESS_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]    host_wdata,
    output logic                     host_gnt,
    output logic [DATA_WIDTH-1:0]    host_rdata,
    output logic                     host_rvalid,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic                     mem_byte_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]    stat_core_stall_cycles,
    output logic [STAT_WIDTH-1:0]    stat_host_grants
`endif
);

    arb_state_t state_q, state_d;
    arb_owner_t owner;
    logic       at_limit;

    // Pick the memory owner; new issues happen only from IDLE and never in reset.
    always_comb begin
        owner = OWN_NONE;
        if (!rst && (state_q == IDLE)) begin
            if (host_req && (!core_req || at_limit)) begin
                owner = OWN_HOST;
            end else if (core_req) begin
                owner = OWN_CORE;
            end
        end
    end

    // Memory port mux, host grant and FSM next state.
    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_byte_en = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        host_gnt    = 1'b0;
        state_d     = state_q;

        case (owner)
            OWN_CORE: begin
                mem_en      = 1'b1;
                mem_we      = core_we;
                mem_byte_en = core_byte_en;
                mem_addr    = core_addr;
                mem_wdata   = core_wdata;
            end
            OWN_HOST: begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                host_gnt  = 1'b1;
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                // Writes finish in the issue cycle; reads wait one cycle for data.
                if ((owner == OWN_CORE) && !core_we) begin
                    state_d = RD_CORE;
                end else if ((owner == OWN_HOST) && !host_we) begin
                    state_d = RD_HOST;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_CORE, RD_HOST: state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // FSM state register; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read return: rvalid is masked during reset so a dropped read never shows.
    assign core_rvalid = !rst && (state_q == RD_CORE);
    assign host_rvalid = !rst && (state_q == RD_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

    // Core proceeds only on its own granted write or when its read data returns.
    assign core_stall = !rst && core_req
                        && !((owner == OWN_CORE) && core_we)
                        && (state_q != RD_CORE);

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (host_req && !host_gnt),
        .clr      (host_gnt || !host_req),
        .at_limit (at_limit)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cnt_q;
    logic [STAT_WIDTH-1:0] gnt_cnt_q;

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            if (core_stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (host_gnt) begin
                gnt_cnt_q <= sat_inc(gnt_cnt_q);
            end
        end
    end

    assign stat_core_stall_cycles = stall_cnt_q;
    assign stat_host_grants       = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int DW    = 20;
    localparam int AW    = 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, core_byte_en;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_rvalid, core_stall;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_en, mem_we, mem_byte_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_core_stall_cycles;
    logic [15:0]   stat_host_grants;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_byte_en (core_byte_en),
        .core_rdata   (core_rdata),
        .core_rvalid  (core_rvalid),
        .core_stall   (core_stall),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_byte_en  (mem_byte_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_core_stall_cycles (stat_core_stall_cycles),
        .stat_host_grants       (stat_host_grants)
`endif
    );

    // Data memory driven by the arbiter: synchronous read, low-byte write option.
    logic [DW-1:0] mem_arr [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (mem_byte_en) mem_arr[mem_addr][7:0] <= mem_wdata[7:0];
                else             mem_arr[mem_addr]      <= mem_wdata;
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] gm [0:255];
    int            m_starve   = 0;
    int            m_pend     = 0;      // 0 none, 1 core read returning, 2 host read returning
    logic [DW-1:0] m_pend_data = '0;
    int            m_stalls   = 0;
    int            m_grants   = 0;
    logic          last_gnt   = 1'b0;
    int            cyc        = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Check one cycle against the model, then advance to the next negedge.
    task automatic tick();
        logic          e_hwin, e_cwin, e_en, e_we, e_be, e_stall, e_crv, e_hrv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_crd, e_hrd;
`ifdef DMEM_ARB_STATS_EN
        chk("stat_stall", 32'(stat_core_stall_cycles), 32'(m_stalls));
        chk("stat_gnt",   32'(stat_host_grants),       32'(m_grants));
`endif
        if (rst) begin
            chk("rst_mem_en",  32'(mem_en),      0);
            chk("rst_mem_we",  32'(mem_we),      0);
            chk("rst_mem_be",  32'(mem_byte_en), 0);
            chk("rst_addr",    32'(mem_addr),    0);
            chk("rst_wdata",   32'(mem_wdata),   0);
            chk("rst_gnt",     32'(host_gnt),    0);
            chk("rst_stall",   32'(core_stall),  0);
            chk("rst_crv",     32'(core_rvalid), 0);
            chk("rst_hrv",     32'(host_rvalid), 0);
            chk("rst_crd",     32'(core_rdata),  0);
            chk("rst_hrd",     32'(host_rdata),  0);
            m_starve = 0;
            m_pend   = 0;
            m_stalls = 0;
            m_grants = 0;
            last_gnt = 1'b0;
            $display("cyc %0d reset", cyc);
        end else begin
            e_crv = (m_pend == 1);
            e_hrv = (m_pend == 2);
            e_crd = e_crv ? m_pend_data : '0;
            e_hrd = e_hrv ? m_pend_data : '0;
            e_hwin = (m_pend == 0) && host_req && (!core_req || (m_starve == LIMIT));
            e_cwin = (m_pend == 0) && !e_hwin && core_req;
            e_en   = e_hwin || e_cwin;
            e_we   = e_hwin ? host_we : (e_cwin ? core_we : 1'b0);
            e_be   = e_cwin && core_byte_en;
            e_addr = e_hwin ? host_addr : core_addr;
            e_wd   = e_hwin ? host_wdata : core_wdata;
            e_stall = core_req && !(e_cwin && core_we) && (m_pend != 1);

            chk("mem_en",      32'(mem_en),      32'(e_en));
            chk("mem_we",      32'(mem_we),      32'(e_we));
            chk("mem_byte_en", 32'(mem_byte_en), 32'(e_be));
            chk("host_gnt",    32'(host_gnt),    32'(e_hwin));
            chk("core_stall",  32'(core_stall),  32'(e_stall));
            chk("core_rvalid", 32'(core_rvalid), 32'(e_crv));
            chk("core_rdata",  32'(core_rdata),  32'(e_crd));
            chk("host_rvalid", 32'(host_rvalid), 32'(e_hrv));
            chk("host_rdata",  32'(host_rdata),  32'(e_hrd));
            if (e_en)         chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            if (e_en && e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));

            if (e_en)
                $display("cyc %0d %s %s a=%02h d=%05h be=%0d", cyc, e_hwin ? "host" : "core",
                         e_we ? "wr" : "rd", e_addr, e_we ? e_wd : gm[e_addr], e_be);

            // Advance the model.
            m_pend = 0;
            if (e_en && !e_we) begin
                m_pend      = e_hwin ? 2 : 1;
                m_pend_data = gm[e_addr];
            end
            if (e_en && e_we) begin
                if (e_be) gm[e_addr][7:0] = e_wd[7:0];
                else      gm[e_addr]      = e_wd;
            end
            if (host_req && !e_hwin) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else                     m_starve = 0;
            if (e_stall && m_stalls < 16'hFFFF) m_stalls++;
            if (e_hwin && m_grants < 16'hFFFF)  m_grants++;
            last_gnt = e_hwin;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_core(input logic req, input logic we, input logic be,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = req; core_we = we; core_byte_en = be; core_addr = a; core_wdata = d;
    endtask

    task automatic set_host(input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = req; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        set_core(1'b1, 1'b0, 1'b0, 8'h05, 20'h0);
        set_host(1'b1, 1'b0, 8'h06, 20'h0);
        @(negedge clk);
        // Reset with requests active: everything stays quiet.
        for (int i = 0; i < 2; i++) begin
            #1; tick();
        end
        rst = 1'b0;
        set_core(1'b0, 1'b0, 1'b0, 8'h0, 20'h0);
        set_host(1'b0, 1'b0, 8'h0, 20'h0);
        #1; tick();

        // Preload the low memory through the host port.
        for (int a = 0; a < 64; a++) begin
            set_host(1'b1, 1'b1, 8'(a), 20'($urandom));
            #1; tick();
        end
        set_host(1'b0, 1'b0, 8'h0, 20'h0);

        // Core write alone.
        set_core(1'b1, 1'b1, 1'b0, 8'h10, 20'h0ABCD);
        #1;
        chk("cwr_mem_we", 32'(mem_we), 1);
        chk("cwr_stall",  32'(core_stall), 0);
        tick();

        // Core read alone: stall at N, data at N+1.
        set_core(1'b1, 1'b0, 1'b0, 8'h10, 20'h0);
        #1;
        chk("crd_en",    32'(mem_en), 1);
        chk("crd_stall", 32'(core_stall), 1);
        tick();
        #1;
        chk("crd_rvalid", 32'(core_rvalid), 1);
        chk("crd_rdata",  32'(core_rdata), 32'h0ABCD);
        chk("crd_stall1", 32'(core_stall), 0);
        tick();

        // Byte write onto 0x12345.
        set_core(1'b1, 1'b1, 1'b0, 8'h30, 20'h12345);
        #1; tick();
        set_core(1'b1, 1'b1, 1'b1, 8'h30, 20'hFFFFF);
        #1;
        chk("bwr_be", 32'(mem_byte_en), 1);
        tick();
        set_core(1'b1, 1'b0, 1'b0, 8'h30, 20'h0);
        #1; tick();
        set_core(1'b0, 1'b0, 1'b0, 8'h0, 20'h0);
        #1;
        chk("bwr_readback", 32'(core_rdata), 32'h123FF);
        tick();

        // Host write then host read of 0x20.
        set_host(1'b1, 1'b1, 8'h20, 20'h00777);
        #1;
        chk("hwr_gnt", 32'(host_gnt), 1);
        tick();
        set_host(1'b1, 1'b0, 8'h20, 20'h0);
        #1;
        chk("hrd_gnt", 32'(host_gnt), 1);
        tick();
        set_host(1'b0, 1'b0, 8'h0, 20'h0);
        #1;
        chk("hrd_rvalid", 32'(host_rvalid), 1);
        chk("hrd_rdata",  32'(host_rdata), 32'h00777);
        tick();

        // Starvation: host write held against a stream of core writes.
        set_host(1'b1, 1'b1, 8'h21, 20'h55555);
        for (int i = 1; i <= LIMIT + 1; i++) begin
            set_core(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), 20'(i));
            #1;
            chk("starve_gnt", 32'(host_gnt), (i == LIMIT + 1) ? 1 : 0);
            if (i == LIMIT + 1) chk("starve_stall", 32'(core_stall), 1);
            tick();
        end
        // Counter restarted: a fresh host request loses to the core again.
        set_host(1'b1, 1'b1, 8'h22, 20'h66666);
        set_core(1'b1, 1'b1, 1'b0, 8'h4F, 20'h1);
        #1;
        chk("starve_restart", 32'(host_gnt), 0);
        tick();
        set_host(1'b0, 1'b0, 8'h0, 20'h0);
        set_core(1'b0, 1'b0, 1'b0, 8'h0, 20'h0);
        #1; tick();

        // Reset the cycle after a core read issue.
        set_core(1'b1, 1'b0, 1'b0, 8'h10, 20'h0);
        #1; tick();
        rst = 1'b1;
        set_core(1'b0, 1'b0, 1'b0, 8'h0, 20'h0);
        #1;
        chk("rstmid_rvalid", 32'(core_rvalid), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_rvalid_after", 32'(core_rvalid), 0);
        chk("rstmid_idle_en",      32'(mem_en), 0);
`ifdef DMEM_ARB_STATS_EN
        chk("rstmid_stat_stall", 32'(stat_core_stall_cycles), 0);
        chk("rstmid_stat_gnt",   32'(stat_host_grants), 0);
`endif
        tick();

        // Randomized traffic; host holds its request until granted.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!(host_req && !last_gnt)) begin
                set_host($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 63)), 20'($urandom));
            end
            set_core($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0, 8'($urandom_range(0, 63)), 20'($urandom));
            #1; tick();
        end

        rst = 1'b0;
        set_core(1'b0, 1'b0, 1'b0, 8'h0, 20'h0);
        set_host(1'b0, 1'b0, 8'h0, 20'h0);
        #1; tick();
        #1; tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single data memory (synchronous read, 1-cycle latency) between the unicycle datapath (core port) and a host loader/debug port.
- Core has fixed priority. A starvation counter forces a host grant after `STARVE_LIMIT` consecutive denied cycles.
- Stalls the core while its access is pending.
- Sits between `datapath_unit` memory signals and the data memory instance.

## Interface
**Parameters**
- `DATA_WIDTH`, 20, memory word width
- `ADDRESS_WIDTH`, 8, memory address width (256 words)
- `STARVE_LIMIT`, 4, consecutive denied host cycles before a forced host grant (≥1)

**Ports**
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; **reset is synchronous and active-high**
- `core_req`  in  1  core access request (from MemRead|MemWrite)
- `core_we`  in  1  1 = write, 0 = read
- `core_addr`  in  ADDRESS_WIDTH  core address
- `core_wdata`  in  DATA_WIDTH  core write data
- `core_byte_en`  in  1  1 = write only bits [7:0] (ByteEnable)
- `core_rdata`  out  DATA_WIDTH  read data to core
- `core_rvalid`  out  1  `core_rdata` valid this cycle
- `core_stall`  out  1  hold PC/pipeline state
- `host_req`  in  1  host access request, held until granted
- `host_we`  in  1  host write select
- `host_addr`  in  ADDRESS_WIDTH  host address
- `host_wdata`  in  DATA_WIDTH  host write data (always full word)
- `host_gnt`  out  1  host request accepted this cycle
- `host_rdata`  out  DATA_WIDTH  read data to host
- `host_rvalid`  out  1  `host_rdata` valid this cycle
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write strobe
- `mem_byte_en`  out  1  low-byte-only write
- `mem_addr`  out  ADDRESS_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after `mem_en` with `!mem_we`

## Operation
**FSM states:** `IDLE`, `RD_CORE`, `RD_HOST`.

**Arbitration (IDLE only)**
- Host wins when `host_req` is high and either `core_req` is low or `starve_cnt == STARVE_LIMIT`.
- Otherwise core wins if `core_req` is high.

**Winner handling**
- Winner drives `mem_*` combinationally the same cycle.
- Write: completes in that cycle; FSM stays `IDLE`.
- Read: FSM moves to `RD_CORE` or `RD_HOST`.

**RD_x state**
- No new issue; `mem_en=0`.
- `x_rvalid=1`, `x_rdata=mem_rdata`.
- Next state is `IDLE`.

**Core stall and host grant**
- `core_stall = core_req & ~(core write granted this cycle) & ~(state==RD_CORE)`.
- `host_gnt=1` in the issue cycle of a host grant (read or write).

**Starvation counter** (`starve_cnt`, width `$clog2(STARVE_LIMIT+1)`)
- Increments on each cycle with `host_req & ~host_gnt`.
- Saturates at `STARVE_LIMIT`.
- Clears on `host_gnt` or `!host_req`.

**Other rules**
- `mem_byte_en` follows the winner: `core_byte_en` for core, 0 for host.
- Unselected `rdata` outputs are driven to 0.

## Timing
- **Reset:** FSM→`IDLE`, `starve_cnt`=0. All outputs are 0 during and after reset until a request arrives.
- **Latency:**
  - Write: 1 cycle (issue cycle).
  - Read: 2 cycles (issue at N, `rvalid` at N+1).
  - Core read: `core_stall` high at N, low at N+1.
- **Back-to-back reads:** the next issue is at N+2 at the earliest.
- **Simultaneous requests, counter below limit:** core wins; host is denied and `starve_cnt` increments.
- **Simultaneous requests, counter at limit:** host wins; core stalls for 1 cycle (host write) or 2 cycles (host read).
- **Reset mid-read:** the in-flight read is dropped, and no `rvalid` is produced after `rst`.
- **Request during RD_x:** the request is held. Denied host cycles still count toward starvation.

## Configuration
- Macro `DMEM_ARB_STATS_EN`, when defined:
  - Adds outputs `stat_core_stall_cycles` [15:0] and `stat_host_grants` [15:0].
  - Both are saturating counters, cleared by `rst`.
  - `stat_core_stall_cycles` increments on every `core_stall` cycle; `stat_host_grants` increments on every `host_gnt`.
- When the macro is undefined, these ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Package `dmem_arb_pkg`:
  - enum `arb_state_t` {IDLE, RD_CORE, RD_HOST}
  - enum `arb_owner_t` {OWN_NONE, OWN_CORE, OWN_HOST}
  - width constant for the stats counters (16)
- One sub-module, `dmem_arb_starve_ctr`: saturating starvation counter with inc/clr inputs and an `at_limit` output.
- The FSM and output multiplexing stay in the top module.

## Test plan
- Core write alone: `core_req=1, core_we=1, addr=0x10, wdata=0x0ABCD`. Expect `mem_we=1` the same cycle, `core_stall=0`, and a later read of 0x10 returns 0x0ABCD.
- Core read alone of 0x10:
  - Cycle N: `mem_en=1`, `core_stall=1`.
  - Cycle N+1: `core_rvalid=1`, `core_rdata=0x0ABCD`, `core_stall=0`.
- Byte write: `core_byte_en=1, wdata=0xFFFFF` to a word holding 0x12345. Expect `mem_byte_en=1`; readback is 0x123FF.
- Starvation: `core_req` and `host_req` held high (host write), `STARVE_LIMIT=4`.
  - Host denied 4 cycles; `host_gnt=1` on cycle 5.
  - `core_stall=1` on cycle 5; `starve_cnt` is 0 the following cycle.
- Host read alone of 0x20 (holding 0x00777): `host_gnt` at N; `host_rvalid=1`, `host_rdata=0x00777` at N+1.
- Reset mid-read: assert `rst` the cycle after a core read issue. Expect `core_rvalid=0` and FSM `IDLE`. With `DMEM_ARB_STATS_EN` defined, both stats counters read 0.
